// File: rtl/sram_slave_mem.sv
// sram_slave_mem: word-addressed on-chip memory, slave side of sram_if.
// One outstanding read with fixed latency RD_LATENCY, read cancellation, and
// single-cycle byte-masked writes. Read data is snapshotted at acceptance.
// Optional feature macro: SRAM_LFSR_LAT_EN adds 0..3 pseudo-random extra
// WAIT cycles per read, drawn from an 8-bit Fibonacci LFSR.
module sram_slave_mem #(
    parameter int unsigned DEPTH        = 4096,
    parameter int unsigned RD_LATENCY   = 2,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NUM_OF_BYTES = DATA_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   sram_rd_addr,
    input  logic                    sram_rd_en,
    input  logic                    sram_cancel_rd,
    output logic                    sram_rd_valid,
    output logic [DATA_WIDTH-1:0]   sram_rd_data,
    input  logic                    sram_wr_en,
    input  logic [ADDR_WIDTH-1:0]   sram_wr_addr,
    input  logic [DATA_WIDTH-1:0]   sram_wr_data,
    input  logic [NUM_OF_BYTES-1:0] sram_wr_mask
);

    localparam int unsigned OFS_W = $clog2(NUM_OF_BYTES);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    // Holds RD_LATENCY-1 (max 15) plus up to 3 LFSR extra cycles.
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   cap_q, cap_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    accept;
    logic [CNT_W-1:0]        extra;
    logic [CNT_W-1:0]        wait_total;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [IDX_W-1:0]        rd_idx, wr_idx;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    unused_addr_bits;

    // Offset and bits above the index are dropped, so addresses wrap modulo DEPTH.
    assign rd_idx  = sram_rd_addr[OFS_W +: IDX_W];
    assign wr_idx  = sram_wr_addr[OFS_W +: IDX_W];
    assign rd_word = mem[rd_idx];
    assign unused_addr_bits = ^{sram_rd_addr, sram_wr_addr};

    // Byte-masked write; independent of the read FSM and never cleared by reset.
    always_ff @(posedge clk) begin
        if (sram_wr_en) begin
            for (int unsigned b = 0; b < NUM_OF_BYTES; b++) begin
                if (sram_wr_mask[b]) begin
                    mem[wr_idx][b*8 +: 8] <= sram_wr_data[b*8 +: 8];
                end
            end
        end
    end

`ifdef SRAM_LFSR_LAT_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic       lfsr_fb;

    // x^8 + x^6 + x^5 + x^4 + 1, stepped once per accepted read.
    assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign lfsr_d  = accept ? {lfsr_q[6:0], lfsr_fb} : lfsr_q;
    assign extra   = CNT_W'(lfsr_q[1:0]);

    // LFSR state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign extra = '0;
`endif

    // Number of WAIT cycles owed by a read accepted this cycle.
    assign wait_total = CNT_W'(RD_LATENCY - 1) + extra;

    // Read FSM next state, snapshot capture and registered output next values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        accept  = 1'b0;

        unique case (state_q)
            StIdle: begin
                accept = sram_rd_en;
            end
            StWait: begin
                if (sram_cancel_rd) begin
                    // Drop the in-flight read; a same-cycle request restarts it.
                    accept  = sram_rd_en;
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StResp: begin
                accept  = sram_rd_en;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            // Read-before-write: the array still holds the pre-edge word.
            cap_d = rd_word;
            if (wait_total == '0) begin
                state_d = StResp;
                cnt_d   = '0;
            end else begin
                state_d = StWait;
                cnt_d   = wait_total - CNT_W'(1);
            end
        end

        rd_valid_d = (state_d == StResp);
        rd_data_d  = (state_d == StResp) ? cap_d : rd_data_q;
    end

    // FSM, snapshot and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            cap_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cap_q      <= cap_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign sram_rd_valid = rd_valid_q;
    assign sram_rd_data  = rd_data_q;

endmodule

// File: tb/tb_sram_slave_mem.sv
// tb_sram_slave_mem: three sram_slave_mem instances (RD_LATENCY 1, 2, 4) share
// one stimulus bus; each vector names the instance whose outputs it checks.
module tb_sram_slave_mem;

    localparam int L1   = 0;
    localparam int L2   = 1;
    localparam int L4   = 2;
    localparam int NONE = 3;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic        cancel;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_mask;
    logic        v1, v2, v4;
    logic [31:0] d1, d2, d4;

    int checks = 0;
    int errors = 0;

    sram_slave_mem #(.DEPTH(4096), .RD_LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .sram_rd_addr(rd_addr), .sram_rd_en(rd_en),
        .sram_cancel_rd(cancel), .sram_rd_valid(v1), .sram_rd_data(d1),
        .sram_wr_en(wr_en), .sram_wr_addr(wr_addr), .sram_wr_data(wr_data),
        .sram_wr_mask(wr_mask)
    );
    sram_slave_mem #(.DEPTH(4096), .RD_LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .sram_rd_addr(rd_addr), .sram_rd_en(rd_en),
        .sram_cancel_rd(cancel), .sram_rd_valid(v2), .sram_rd_data(d2),
        .sram_wr_en(wr_en), .sram_wr_addr(wr_addr), .sram_wr_data(wr_data),
        .sram_wr_mask(wr_mask)
    );
    sram_slave_mem #(.DEPTH(4096), .RD_LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .sram_rd_addr(rd_addr), .sram_rd_en(rd_en),
        .sram_cancel_rd(cancel), .sram_rd_valid(v4), .sram_rd_data(d4),
        .sram_wr_en(wr_en), .sram_wr_addr(wr_addr), .sram_wr_data(wr_data),
        .sram_wr_mask(wr_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        re;
        logic [31:0] ra;
        logic        cn;
        logic        we;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [3:0]  wm;
        int          inst;
        logic        ev;
        logic [31:0] ed;
        logic        cd;
        string       nm;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic r, input logic re, input logic [31:0] ra,
                               input logic cn, input logic we, input logic [31:0] wa,
                               input logic [31:0] wd, input logic [3:0] wm, input int inst,
                               input logic ev, input logic [31:0] ed, input logic cd,
                               input string nm);
        vec_t t;
        t.r = r; t.re = re; t.ra = ra; t.cn = cn; t.we = we; t.wa = wa; t.wd = wd;
        t.wm = wm; t.inst = inst; t.ev = ev; t.ed = ed; t.cd = cd; t.nm = nm;
        return t;
    endfunction

    function automatic vec_t nop(input int inst, input logic ev, input logic [31:0] ed,
                                 input logic cd, input string nm);
        return v(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, inst, ev, ed, cd, nm);
    endfunction

    task automatic drive(input logic r, input logic re, input logic [31:0] ra, input logic cn,
                         input logic we, input logic [31:0] wa, input logic [31:0] wd,
                         input logic [3:0] wm);
        rst = r; rd_en = re; rd_addr = ra; cancel = cn;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_mask = wm;
    endtask

    task automatic chk(input int inst, input logic ev, input logic [31:0] ed, input logic cd,
                       input string nm);
        logic        av;
        logic [31:0] ad;
        case (inst)
            L1: begin av = v1; ad = d1; end
            L2: begin av = v2; ad = d2; end
            L4: begin av = v4; ad = d4; end
            default: return;
        endcase
        checks++;
        if (av !== ev) begin
            errors++;
            $display("FAIL %s: rd_valid got %0b expected %0b", nm, av, ev);
        end
        if (cd) begin
            checks++;
            if (ad !== ed) begin
                errors++;
                $display("FAIL %s: rd_data got %h expected %h", nm, ad, ed);
            end
        end
    endtask

    initial begin
        int n;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Reset, write, RD_LATENCY=2 read with hold.
        tbl.push_back(v(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, NONE, 0, 32'h0, 0, "reset"));
        tbl.push_back(v(0, 0, 32'h0, 0, 1, 32'h1000, 32'hDEADBEEF, 4'hF, L2, 0, 32'h0, 1,
                        "rst_state"));
        tbl.push_back(v(0, 1, 32'h1000, 0, 0, 32'h0, 32'h0, 4'h0, L2, 0, 32'h0, 1, "pre_read"));
        tbl.push_back(nop(L2, 0, 32'h0, 1, "lat2_c1"));
        tbl.push_back(nop(L2, 1, 32'hDEADBEEF, 1, "lat2_c2"));
        // Byte mask.
        tbl.push_back(v(0, 0, 32'h0, 0, 1, 32'h20, 32'h11223344, 4'hF, L2, 0, 32'hDEADBEEF, 1,
                        "lat2_c3"));
        tbl.push_back(v(0, 0, 32'h0, 0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, L2, 0, 32'h0, 0,
                        "idle_a"));
        tbl.push_back(v(0, 1, 32'h20, 0, 0, 32'h0, 32'h0, 4'h0, L2, 0, 32'h0, 0, "idle_b"));
        tbl.push_back(nop(L2, 0, 32'h0, 0, "mask_c1"));
        tbl.push_back(v(0, 0, 32'h0, 0, 1, 32'h40, 32'h0, 4'hF, L2, 1, 32'h11BB33DD, 1,
                        "mask_rsp"));
        // Same-edge read/write collision, then back-to-back read from RESP.
        tbl.push_back(v(0, 1, 32'h40, 0, 1, 32'h40, 32'h5, 4'hF, L2, 0, 32'h11BB33DD, 1,
                        "mask_hold"));
        tbl.push_back(nop(L2, 0, 32'h0, 0, "coll_c1"));
        tbl.push_back(v(0, 1, 32'h40, 0, 0, 32'h0, 32'h0, 4'h0, L2, 1, 32'h0, 1, "coll_old"));
        tbl.push_back(nop(L2, 0, 32'h0, 0, "coll2_c1"));
        tbl.push_back(nop(L2, 1, 32'h5, 1, "coll_new"));
        // RD_LATENCY=1 back-to-back and address wrap.
        tbl.push_back(v(0, 0, 32'h0, 0, 1, 32'h0, 32'h11110000, 4'hF, L2, 0, 32'h5, 1,
                        "coll_hold"));
        tbl.push_back(v(0, 0, 32'h0, 0, 1, 32'h4, 32'h22220004, 4'hF, NONE, 0, 32'h0, 0, "w4"));
        tbl.push_back(v(0, 1, 32'h0, 0, 1, 32'h8, 32'h33330008, 4'hF, NONE, 0, 32'h0, 0, "w8"));
        tbl.push_back(v(0, 1, 32'h4, 0, 0, 32'h0, 32'h0, 4'h0, L1, 1, 32'h11110000, 1, "b2b_0"));
        tbl.push_back(v(0, 1, 32'h8, 0, 0, 32'h0, 32'h0, 4'h0, L1, 1, 32'h22220004, 1, "b2b_4"));
        tbl.push_back(v(0, 1, 32'h4004, 0, 0, 32'h0, 32'h0, 4'h0, L1, 1, 32'h33330008, 1,
                        "b2b_8"));
        tbl.push_back(nop(L1, 1, 32'h22220004, 1, "wrap"));
        // RD_LATENCY=4 cancel without and with a replacement read.
        tbl.push_back(v(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, L1, 0, 32'h22220004, 1,
                        "b2b_end"));
        tbl.push_back(v(0, 1, 32'h1000, 0, 0, 32'h0, 32'h0, 4'h0, L4, 0, 32'h0, 1, "l4_rst"));
        tbl.push_back(nop(L4, 0, 32'h0, 1, "cxl_c1"));
        tbl.push_back(v(0, 0, 32'h0, 1, 0, 32'h0, 32'h0, 4'h0, L4, 0, 32'h0, 1, "cxl_c2"));
        for (int i = 0; i < 6; i++) tbl.push_back(nop(L4, 0, 32'h0, 1, "cxl_quiet"));
        tbl.push_back(v(0, 1, 32'h1000, 0, 0, 32'h0, 32'h0, 4'h0, L4, 0, 32'h0, 1, "cxl_c9"));
        tbl.push_back(nop(L4, 0, 32'h0, 1, "cxlb_c1"));
        tbl.push_back(v(0, 1, 32'h20, 1, 0, 32'h0, 32'h0, 4'h0, L4, 0, 32'h0, 1, "cxlb_c2"));
        tbl.push_back(nop(L4, 0, 32'h0, 1, "cxlb_c3"));
        tbl.push_back(nop(L4, 0, 32'h0, 1, "cxlb_c4"));
        tbl.push_back(nop(L4, 0, 32'h0, 1, "cxlb_c5"));
        tbl.push_back(nop(L4, 1, 32'h11BB33DD, 1, "cxlb_rsp"));
        tbl.push_back(nop(L4, 0, 32'h11BB33DD, 1, "cxlb_hold"));
        // Reset while RD_LATENCY=2 read is in WAIT; memory survives reset.
        tbl.push_back(v(0, 1, 32'h20, 0, 0, 32'h0, 32'h0, 4'h0, NONE, 0, 32'h0, 0, "rstw_rd"));
        tbl.push_back(v(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, L2, 0, 32'h0, 0, "rstw_c1"));
        tbl.push_back(nop(L2, 0, 32'h0, 1, "rstw_c2"));
        tbl.push_back(nop(L2, 0, 32'h0, 1, "rstw_c3"));
        tbl.push_back(v(0, 1, 32'h1000, 0, 0, 32'h0, 32'h0, 4'h0, L2, 0, 32'h0, 1, "rstw_c4"));
        tbl.push_back(nop(L2, 0, 32'h0, 1, "keep_c1"));
        tbl.push_back(nop(L2, 1, 32'hDEADBEEF, 1, "keep_mem"));
        tbl.push_back(nop(L2, 0, 32'hDEADBEEF, 1, "keep_end"));

        // Each vector: check this cycle's registered outputs, then drive this cycle's inputs.
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            chk(tbl[i].inst, tbl[i].ev, tbl[i].ed, tbl[i].cd, tbl[i].nm);
            drive(tbl[i].r, tbl[i].re, tbl[i].ra, tbl[i].cn, tbl[i].we, tbl[i].wa, tbl[i].wd,
                  tbl[i].wm);
        end

        // Cancel in IDLE is ignored; RD_LATENCY=4 measured with a bounded wait.
        @(negedge clk); drive(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);
        @(negedge clk); drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);
        @(negedge clk); drive(0, 0, 32'h0, 1, 0, 32'h0, 32'h0, 4'h0);
        @(negedge clk); drive(0, 1, 32'h20, 0, 0, 32'h0, 32'h0, 4'h0);
        @(negedge clk); drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);
        n = 1;
        while (v4 !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (v4 !== 1'b1 || n != 4) begin
            errors++;
            $display("FAIL lat4_count: rd_valid seen in cycle %0d (valid=%0b) expected 4", n, v4);
        end
        chk(L4, 1'b1, 32'h11BB33DD, 1'b1, "lat4_data");

        // Cancel during RESP is ignored and a same-cycle read is accepted back-to-back.
        @(negedge clk); drive(0, 1, 32'h40, 0, 0, 32'h0, 32'h0, 4'h0);
        @(negedge clk); drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk(L2, 1'b1, 32'h5, 1'b1, "resp_cxl_rsp");
        drive(0, 1, 32'h1000, 1, 0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk(L2, 1'b0, 32'h5, 1'b1, "resp_cxl_c1");
        drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk(L2, 1'b1, 32'hDEADBEEF, 1'b1, "resp_cxl_b2b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_slave_mem.md
# sram_slave_mem

Word-addressed on-chip memory that implements the slave (`s`) side of `sram_if` and serves the core's SRAM masters (fetch / LSU) in simulation and FPGA builds. It accepts one outstanding read at a time with a parameterized fixed latency and honours read cancellation. Byte-masked writes complete in a single cycle. Read data is a snapshot taken when the read is accepted, so the memory's behaviour is fully deterministic for the masters upstream.

## Interface
- `DEPTH`, 4096: number of `DATA_WIDTH` words (power of two).
- `RD_LATENCY`, 2: cycles from read acceptance to `sram_rd_valid` (1..16).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high. One clock domain only.
- `sram_rd_addr` in `ADDR_WIDTH`: byte address of the read.
- `sram_rd_en` in 1: read request.
- `sram_cancel_rd` in 1: abort the in-flight read.
- `sram_rd_valid` out 1: read response strobe, high for exactly one cycle per response.
- `sram_rd_data` out `DATA_WIDTH`: read response data.
- `sram_wr_en` in 1: write strobe.
- `sram_wr_addr` in `ADDR_WIDTH`: byte address of the write.
- `sram_wr_data` in `DATA_WIDTH`: write data.
- `sram_wr_mask` in `NUM_OF_BYTES`: bit i enables byte i of the write.
- Port group equals modport `sram_if.s`. Widths come from `width_param.sv`.

## Operation
- Word index = `addr[log2(NUM_OF_BYTES) +: log2(DEPTH)]`. Low offset bits are ignored. Address bits above the index are ignored, so addresses wrap modulo DEPTH.
- Writes:
  - Performed at the clock edge where `sram_wr_en`=1.
  - Only masked bytes are updated. `wr_mask`=0 is a no-op.
  - Writes never stall and are independent of the read FSM.
- Read acceptance (at the edge): captures `mem[idx]` into the data register. Same-edge write to the same word yields OLD data (read-before-write). Later writes do not alter the captured data.
- FSM states are IDLE, WAIT, RESP.
  - IDLE, `rd_en`=1: accept. If `RD_LATENCY`=1, go to RESP. Otherwise go to WAIT with `cnt`=RD_LATENCY-2.
  - WAIT, `cancel`=1: drop the in-flight read. If `rd_en`=1 in the same cycle, accept the new read as from IDLE. Otherwise go to IDLE.
  - WAIT, `cancel`=0: if `cnt`=0, go to RESP; else decrement `cnt`. `rd_en` is ignored here, and the master must not rely on it.
  - RESP: `sram_rd_valid`=1 and `sram_rd_data` = captured word. If `rd_en`=1, accept (back-to-back). Otherwise go to IDLE. `cancel` is ignored because the response has already been delivered.
- IDLE, `cancel`=1: ignored.
- `sram_rd_data` holds its last returned value when `rd_valid`=0.
- `rst`:
  - Resets to IDLE, `sram_rd_valid`=0, `sram_rd_data`=0, `cnt`=0.
  - Any in-flight read is dropped silently.
  - Memory contents are NOT cleared.

## Timing
- Request sampled at the end of cycle 0 → `sram_rd_valid` high in cycle RD_LATENCY (with the LFSR feature off).
- Maximum read throughput is 1 per RD_LATENCY cycles. With RD_LATENCY=1, a new read every cycle gives continuous `rd_valid`.
- Write is visible to a read accepted at the following edge (1-cycle write-to-read).
- `sram_rd_valid` and `sram_rd_data` are registered outputs. There is no combinational path from any input to any output.
- `rst` asserted in any state: outputs take their reset values in the next cycle.

## Configuration
- `SRAM_LFSR_LAT_EN`
  - Defined: adds an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), reset to 8'hA5.
  - The LFSR advances once per accepted read.
  - `lfsr[1:0]` sampled at acceptance adds 0..3 extra WAIT cycles to that read. RD_LATENCY=1 with extra>0 goes through WAIT.
  - Used to stress master handshakes.
- Undefined: latency is exactly RD_LATENCY and no LFSR logic exists.

## Test plan
- Reset, RD_LATENCY=2: write 0x1000 data 0xDEADBEEF mask 4'hF, read 0x1000 at cycle 0 → `rd_valid` only in cycle 2 with 0xDEADBEEF, then 0 in cycle 3.
- Byte mask: mem[0x20]=0x11223344, then write 0xAABBCCDD mask 4'b0101 → read returns 0x11BB33DD.
- Collision: read and write of 0x40 on the same edge (old 0x0, new 0x5) → response 0x0. A following read → 0x5.
- Cancel, RD_LATENCY=4:
  - Read A, assert cancel in cycle 2 with no `rd_en` → no `rd_valid` for 8 cycles.
  - Repeat with `rd_en` for B in the cancel cycle → only B's data returns, in cycle 6.
- Back-to-back, RD_LATENCY=1: reads of 0x0, 0x4, 0x8 in consecutive cycles → `rd_valid` in cycles 1–3 with the matching data. Address 0x4 + DEPTH*4 returns the same word as 0x4.
- `rst` asserted in WAIT → `rd_valid` never asserts for that read, `rd_data`=0, and previously written memory is preserved.
